// File: rtl/ram_uart_sequencer.sv
// rtl/ram_uart_sequencer.sv - packs UART bytes into SRAM words, then reads them back out to the UART
// Optional macro RAM_TIMEOUT_EN: abort to IDLE with sticky err when a done edge takes TIMEOUT cycles.
module ram_uart_sequencer #(
  parameter int unsigned WORDS     = 10,
  parameter logic [17:0] BASE_ADDR = 18'h00000,
  parameter int unsigned TIMEOUT   = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        ctl_en,
  output logic        ctl_we,
  output logic        ctl_re,
  output logic [17:0] ctl_addr,
  output logic [15:0] ctl_wdata,
  input  logic [15:0] ctl_rdata,
  input  logic        ctl_done,
  output logic        busy,
  output logic        err
);

  typedef enum logic [3:0] {
    S_IDLE, S_RX_LO, S_RX_HI, S_WR_REQ, S_WR_REL,
    S_RD_REQ, S_RD_REL, S_TX_LO, S_TX_HI
  } state_t;

  state_t      state, state_next;
  logic        done_m, done_s;
  logic [17:0] cnt;
  logic [15:0] rdata_q;
  logic        last_word;
  logic        load_base, step, cap_lo, cap_hi, cap_rd;

  assign last_word = (cnt == 18'(WORDS - 1));
  assign ctl_en    = (state != S_IDLE);
  assign busy      = (state != S_IDLE);

  // ctl_done comes from another clock domain; only done_s may steer the FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_m <= 1'b0;
      done_s <= 1'b0;
    end else begin
      done_m <= ctl_done;
      done_s <= done_m;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

`ifdef RAM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wait_cnt;
  logic          waiting;
  logic          timeout_hit;

  assign waiting = (state == S_WR_REQ) || (state == S_WR_REL) ||
                   (state == S_RD_REQ) || (state == S_RD_REL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      wait_cnt <= '0;
    else if (state_next != state) wait_cnt <= '0;
    else if (waiting)             wait_cnt <= wait_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              err <= 1'b0;
    else if (timeout_hit) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

  always_comb begin
    state_next = state;
    load_base  = 1'b0;
    step       = 1'b0;
    cap_lo     = 1'b0;
    cap_hi     = 1'b0;
    cap_rd     = 1'b0;
    ctl_we     = 1'b0;
    ctl_re     = 1'b0;
    tx_valid   = 1'b0;
    tx_data    = 8'h00;
`ifdef RAM_TIMEOUT_EN
    timeout_hit = 1'b0;
`endif
    case (state)
      S_IDLE: if (start) begin
        load_base  = 1'b1;
        state_next = S_RX_LO;
      end
      S_RX_LO: if (rx_valid) begin
        cap_lo     = 1'b1;
        state_next = S_RX_HI;
      end
      S_RX_HI: if (rx_valid) begin
        cap_hi     = 1'b1;
        state_next = S_WR_REQ;
      end
      S_WR_REQ: begin
        ctl_we = 1'b1;
        if (done_s) state_next = S_WR_REL;
      end
      S_WR_REL: if (!done_s) begin
        if (last_word) begin
          load_base  = 1'b1;
          state_next = S_RD_REQ;
        end else begin
          step       = 1'b1;
          state_next = S_RX_LO;
        end
      end
      S_RD_REQ: begin
        ctl_re = 1'b1;
        if (done_s) begin
          cap_rd     = 1'b1;
          state_next = S_RD_REL;
        end
      end
      S_RD_REL: if (!done_s) state_next = S_TX_LO;
      S_TX_LO: begin
        tx_valid = 1'b1;
        tx_data  = rdata_q[7:0];
        if (tx_ready) state_next = S_TX_HI;
      end
      S_TX_HI: begin
        tx_valid = 1'b1;
        tx_data  = rdata_q[15:8];
        if (tx_ready) begin
          if (last_word) begin
            state_next = S_IDLE;
          end else begin
            step       = 1'b1;
            state_next = S_RD_REQ;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
`ifdef RAM_TIMEOUT_EN
    // a done edge that arrives on the last allowed cycle still wins over the abort
    if (waiting && (wait_cnt == TW'(TIMEOUT - 1)) && (state_next == state)) begin
      timeout_hit = 1'b1;
      ctl_we      = 1'b0;
      ctl_re      = 1'b0;
      state_next  = S_IDLE;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      ctl_addr  <= '0;
      ctl_wdata <= '0;
      rdata_q   <= '0;
    end else begin
      if (load_base) begin
        cnt      <= '0;
        ctl_addr <= BASE_ADDR;
      end else if (step) begin
        cnt      <= cnt + 18'd1;
        ctl_addr <= ctl_addr + 18'd1;
      end
      if (cap_lo) ctl_wdata[7:0]  <= rx_data;
      if (cap_hi) ctl_wdata[15:8] <= rx_data;
      if (cap_rd) rdata_q         <= ctl_rdata;
    end
  end

endmodule

// File: tb/tb_ram_uart_sequencer.sv
// tb/tb_ram_uart_sequencer.sv - randomized self-checking bench for ram_uart_sequencer
// Controller and UART sides are modelled; the model predicts writes and transmitted bytes from the rx stream.
module tb_ram_uart_sequencer;
  localparam int          WORDS = 3;
  localparam logic [17:0] BASE  = 18'h3FFFE;

  logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        ctl_en, ctl_we, ctl_re;
  logic [17:0] ctl_addr;
  logic [15:0] ctl_wdata;
  logic [15:0] ctl_rdata = 16'h0000;
  logic        ctl_done = 1'b0;
  logic        busy, err;

  always #5 clk = ~clk;

  ram_uart_sequencer #(.WORDS(WORDS), .BASE_ADDR(BASE), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .ctl_en(ctl_en), .ctl_we(ctl_we), .ctl_re(ctl_re), .ctl_addr(ctl_addr),
    .ctl_wdata(ctl_wdata), .ctl_rdata(ctl_rdata), .ctl_done(ctl_done),
    .busy(busy), .err(err)
  );

  int errors = 0, checks = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // SRAM controller: acknowledges after ack_lat cycles, holds done at least min_hold cycles
  logic [15:0] mem [logic [17:0]];
  int ack_lat = 5, min_hold = 0, rel_lat = 1;
  bit no_ack = 1'b0;
  int wait_c = 0, hold_c = 0, rel_c = 0;
  always @(posedge clk) begin
    #2;
    if (rst) begin
      ctl_done = 1'b0;
      wait_c   = 0;
    end else if (!ctl_done) begin
      if ((ctl_we || ctl_re) && !no_ack) begin
        wait_c++;
        if (wait_c >= ack_lat) begin
          if (ctl_we) mem[ctl_addr] = ctl_wdata;
          else        ctl_rdata = mem.exists(ctl_addr) ? mem[ctl_addr] : 16'h0000;
          ctl_done = 1'b1;
          wait_c = 0; hold_c = 0; rel_c = 0;
        end
      end else begin
        wait_c = 0;
      end
    end else begin
      hold_c++;
      if (!(ctl_we || ctl_re)) rel_c++;
      if (!(ctl_we || ctl_re) && hold_c >= min_hold && rel_c > rel_lat) ctl_done = 1'b0;
    end
  end

  // UART transmitter: random acceptance, optional 20-cycle stall on the second byte of a pass
  logic [7:0] tx_log [$];
  int bp_cnt = 0;
  bit bp_arm = 1'b0;
  always @(posedge clk) begin
    #2;
    if (bp_arm && tx_valid && tx_log.size() == 1) begin
      bp_arm = 1'b0;
      bp_cnt = 20;
    end
    if (bp_cnt > 0) begin
      tx_ready = 1'b0;
      bp_cnt--;
    end else begin
      tx_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // compare process
  logic [17:0] exp_wa [$];
  logic [15:0] exp_wd [$];
  logic [7:0]  exp_tx [$];
  int wr_count = 0, rd_count = 0, done_age = 0;
  bit expect_err = 1'b0;
  logic p_done = 0, p_req = 0, p_we = 0, p_tv = 0, p_tr = 0;
  logic [7:0]  p_td = 0;
  logic [17:0] p_addr = 0;
  logic [15:0] p_wd = 0;
  always @(negedge clk) begin
    if (rst) begin
      p_done = 0; p_req = 0; p_we = 0; p_tv = 0; p_tr = 0; done_age = 0;
    end else begin
      chk("en_busy_agree", ctl_en, busy);
      chk("we_re_exclusive", ctl_we & ctl_re, 1'b0);
      if (!expect_err) chk("err_low", err, 1'b0);
      if ((ctl_we | ctl_re) && !p_req) chk("req_only_after_done_low", ctl_done, 1'b0);
      if (ctl_done && !p_done) done_age = 1;
      else if (ctl_done)       done_age++;
      else                     done_age = 0;
      if (ctl_done && (ctl_we | ctl_re)) chk("release_within_3", done_age <= 3, 1'b1);
      if (ctl_done && !p_done && ctl_we) begin
        wr_count++;
        chk("write_expected", exp_wa.size() > 0, 1'b1);
        if (exp_wa.size() > 0) begin
          chk("wr_addr", ctl_addr, exp_wa.pop_front());
          chk("wr_data", ctl_wdata, exp_wd.pop_front());
        end
      end
      if (ctl_done && !p_done && ctl_re) rd_count++;
      if (p_we && ctl_we) begin
        chk("wr_addr_stable", ctl_addr, p_addr);
        chk("wr_data_stable", ctl_wdata, p_wd);
      end
      if (p_tv && !p_tr) begin
        chk("tx_valid_held", tx_valid, 1'b1);
        chk("tx_data_held", tx_data, p_td);
      end
      if (tx_valid && tx_ready) begin
        tx_log.push_back(tx_data);
        chk("tx_expected", exp_tx.size() > 0, 1'b1);
        if (exp_tx.size() > 0) chk("tx_byte", tx_data, exp_tx.pop_front());
      end
      p_done = ctl_done; p_req = ctl_we | ctl_re; p_we = ctl_we;
      p_tv = tx_valid; p_tr = tx_ready; p_td = tx_data;
      p_addr = ctl_addr; p_wd = ctl_wdata;
    end
  end

  logic [7:0] pb [0:2*WORDS-1];

  task automatic send_byte(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic clear_model();
    exp_wa.delete(); exp_wd.delete(); exp_tx.delete(); tx_log.delete();
  endtask

  task automatic reset_pulse();
    #1 rst = 1'b1;
    #1;
    chk("rst_ctl_en", ctl_en, 1'b0);
    chk("rst_ctl_we", ctl_we, 1'b0);
    chk("rst_ctl_re", ctl_re, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_ctl_addr", ctl_addr, 18'h0);
    chk("rst_ctl_wdata", ctl_wdata, 16'h0);
    chk("rst_err", err, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_model();
    @(negedge clk);
  endtask

  task automatic run_pass(input bit abort);
    int w0, r0, budget;
    bit junk;
    logic [17:0] a;
    clear_model();
    for (int i = 0; i < WORDS; i++) begin
      a = BASE + 18'(i);
      exp_wa.push_back(a);
      exp_wd.push_back({pb[2*i+1], pb[2*i]});
      exp_tx.push_back(pb[2*i]);
      exp_tx.push_back(pb[2*i+1]);
    end
    w0 = wr_count; r0 = rd_count;
    pulse_start();
    for (int w = 0; w < WORDS; w++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send_byte(pb[2*w]);
      if (w == 1) pulse_start();
      send_byte(pb[2*w+1]);
      budget = 0; junk = 1'b0;
      while (wr_count < w0 + w + 1 && budget < 200) begin
        if (ctl_we && !junk) begin
          rx_data = 8'($urandom); rx_valid = 1'b1; junk = 1'b1;
        end else begin
          rx_valid = 1'b0;
        end
        @(negedge clk);
        budget++;
      end
      rx_valid = 1'b0;
      chk("write_issued", wr_count - w0, w + 1);
      if (w < WORDS - 1) begin
        budget = 0;
        while (ctl_done && budget < 200) begin @(negedge clk); budget++; end
        repeat (4) @(negedge clk);
      end
    end
    if (abort) begin
      budget = 0;
      while (!ctl_re && budget < 300) begin @(negedge clk); budget++; end
      chk("reached_rd_req", ctl_re, 1'b1);
      reset_pulse();
    end else begin
      budget = 0;
      while (busy && budget < 3000) begin @(negedge clk); budget++; end
      chk("pass_done_idle", busy, 1'b0);
      chk("tx_all_sent", exp_tx.size(), 0);
      chk("writes_per_pass", wr_count - w0, WORDS);
      chk("reads_per_pass", rd_count - r0, WORDS);
    end
  endtask

  initial begin
    #12;
    chk("reset_busy", busy, 1'b0);
    chk("reset_ctl_en", ctl_en, 1'b0);
    chk("reset_tx_valid", tx_valid, 1'b0);
    chk("reset_tx_data", tx_data, 8'h00);
    chk("reset_ctl_addr", ctl_addr, 18'h0);
    chk("reset_ctl_wdata", ctl_wdata, 16'h0);
    chk("reset_err", err, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // fixed pass: byte order, address wrap, back-pressure, long done hold
    pb[0] = 8'h34; pb[1] = 8'h12; pb[2] = 8'hCD; pb[3] = 8'hAB; pb[4] = 8'h78; pb[5] = 8'h56;
    ack_lat = 5; min_hold = 10; rel_lat = 1; bp_arm = 1'b1;
    run_pass(1'b0);
    chk("lit_mem_3fffe", mem[18'h3FFFE], 16'h1234);
    chk("lit_mem_3ffff", mem[18'h3FFFF], 16'hABCD);
    chk("lit_mem_00000", mem[18'h00000], 16'h5678);
    chk("lit_tx_count", tx_log.size(), 6);
    if (tx_log.size() == 6) begin
      chk("lit_tx0", tx_log[0], 8'h34);
      chk("lit_tx1", tx_log[1], 8'h12);
      chk("lit_tx2", tx_log[2], 8'hCD);
      chk("lit_tx3", tx_log[3], 8'hAB);
      chk("lit_tx4", tx_log[4], 8'h78);
      chk("lit_tx5", tx_log[5], 8'h56);
    end

    for (int p = 0; p < 3; p++) begin
      foreach (pb[i]) pb[i] = 8'($urandom);
      ack_lat = $urandom_range(1, 8); min_hold = $urandom_range(0, 3); rel_lat = $urandom_range(0, 3);
      run_pass(1'b0);
    end

    foreach (pb[i]) pb[i] = 8'($urandom);
    run_pass(1'b1);
    foreach (pb[i]) pb[i] = 8'($urandom);
    run_pass(1'b0);

    // controller that never acknowledges
    no_ack = 1'b1;
`ifdef RAM_TIMEOUT_EN
    expect_err = 1'b1;
`endif
    pulse_start();
    send_byte(8'h11);
    send_byte(8'h22);
    repeat (30) @(negedge clk);
`ifdef RAM_TIMEOUT_EN
    chk("timeout_err", err, 1'b1);
    chk("timeout_we_low", ctl_we, 1'b0);
    chk("timeout_idle", busy, 1'b0);
`else
    chk("stall_busy", busy, 1'b1);
    chk("stall_we_high", ctl_we, 1'b1);
    chk("stall_err_low", err, 1'b0);
`endif
    reset_pulse();
    no_ack = 1'b0;
    expect_err = 1'b0;
    chk("err_cleared", err, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
